nios2_debug_cmd_queue: RTL and testbench

Parametrised system-clock-side command receiver for the Nios II JTAG debug slave. It synchronises the virtual-JTAG update-IR and update-DR strobes into `clk`, then captures the instruction register and the debug shift register on each update. Each captured command is queued in a small FIFO so back-to-back JTAG updates are not lost while the CPU debug logic is busy. Each command is issued as a valid/ready transaction plus one-hot per-IR-code take_action / take_no_action pulses. It replaces the fixed 2-bit-IR, 38-bit, unbuffered sysclk decoder.

---
 rtl/nios2_debug_pkg.sv | 15 +
 rtl/nios2_debug_sync_edge.sv | 42 ++++
 rtl/nios2_debug_cmd_queue.sv | 110 +++++++++++
 tb/tb_nios2_debug_cmd_queue.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nios2_debug_pkg.sv
// Shared definitions for the Nios II debug command path.
// IR codes, default widths and the per-channel index type.
package nios2_debug_pkg;

    localparam int SR_W_DEF = 38;
    localparam int IR_W_DEF = 2;

    localparam logic [IR_W_DEF-1:0] IR_MONITOR   = 2'd0;
    localparam logic [IR_W_DEF-1:0] IR_BREAK     = 2'd1;
    localparam logic [IR_W_DEF-1:0] IR_TRACE     = 2'd2;
    localparam logic [IR_W_DEF-1:0] IR_TRACECTRL = 2'd3;

    typedef logic [IR_W_DEF-1:0] ch_idx_t;

endpackage

// File: rtl/nios2_debug_sync_edge.sv
// Level synchroniser plus rising-edge pulse for TCK-domain strobes.
// Depth is 3 flops with NIOS2_DBG_SYNC3_EN defined, otherwise 2.
module nios2_debug_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic pulse
);

`ifdef NIOS2_DBG_SYNC3_EN
    localparam int STAGES = 3;
`else
    localparam int STAGES = 2;
`endif

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] prime_q;
    logic              hist_q;
    logic              armed_q;
    logic              lvl;

    assign lvl = sync_q[STAGES-1];

    // A strobe already high out of reset must be seen low before it can fire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q  <= '0;
            prime_q <= '0;
            hist_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[STAGES-2:0], d};
            prime_q <= {prime_q[STAGES-2:0], 1'b1};
            hist_q  <= lvl;
            if (prime_q[STAGES-1] && !lvl)
                armed_q <= 1'b1;
        end
    end

    assign pulse = lvl & ~hist_q & armed_q;

endmodule

// File: rtl/nios2_debug_cmd_queue.sv
// Sysclk-side JTAG debug command receiver with a first-word fall-through queue.
// Synchroniser depth is selected by NIOS2_DBG_SYNC3_EN.
module nios2_debug_cmd_queue
    import nios2_debug_pkg::*;
#(
    parameter int SR_W    = SR_W_DEF,
    parameter int IR_W    = IR_W_DEF,
    parameter int DEPTH   = 4,
    parameter int ACT_BIT = 37
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     vs_uir,
    input  logic                     vs_udr,
    input  logic [IR_W-1:0]          ir_in,
    input  logic [SR_W-1:0]          sr,
    input  logic                     cmd_ready,
    input  logic                     ovf_clr,
    output logic                     cmd_valid,
    output logic [IR_W-1:0]          cmd_ir,
    output logic [SR_W-1:0]          jdo,
    output logic [(2**IR_W)-1:0]     take_action,
    output logic [(2**IR_W)-1:0]     take_no_action,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf
);

    localparam int NCH = 2**IR_W;
    localparam int PW  = $clog2(DEPTH);
    localparam int LW  = PW + 1;
    localparam int EW  = IR_W + SR_W;

    logic uir_p;
    logic udr_p;

    nios2_debug_sync_edge u_uir (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (vs_uir),
        .pulse   (uir_p)
    );

    nios2_debug_sync_edge u_udr (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (vs_udr),
        .pulse   (udr_p)
    );

    logic [IR_W-1:0] ir_q;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic            ovf_q;

    logic            full;
    logic            pop;
    logic            push;
    logic            drop;
    logic [IR_W-1:0] push_ir;
    logic [EW-1:0]   head;
    logic [NCH-1:0]  onehot;

    assign full    = (level_q == LW'(DEPTH));
    assign pop     = cmd_valid & cmd_ready;
    // A pop frees the slot in the same cycle, so full+pop still accepts.
    assign push    = udr_p & (~full | pop);
    assign drop    = udr_p & full & ~pop;
    assign push_ir = uir_p ? ir_in : ir_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            if (uir_p)
                ir_q <= ir_in;
            if (push) begin
                mem_q[wr_ptr_q] <= {push_ir, sr};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_q + LW'(push) - LW'(pop);
            if (drop)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign cmd_valid = (level_q != '0);
    assign cmd_ir    = cmd_valid ? head[EW-1:SR_W] : '0;
    assign jdo       = cmd_valid ? head[SR_W-1:0] : '0;
    assign onehot    = NCH'(1) << cmd_ir;

    assign take_action    = (pop &  jdo[ACT_BIT]) ? onehot : '0;
    assign take_no_action = (pop & ~jdo[ACT_BIT]) ? onehot : '0;

    assign level = level_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_nios2_debug_cmd_queue.sv
// Self-checking bench for nios2_debug_cmd_queue.
// Scoreboard of expected pops plus a table of single-command vectors.
module tb_nios2_debug_cmd_queue;
    import nios2_debug_pkg::*;

`ifdef NIOS2_DBG_SYNC3_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        vs_uir = 1'b0;
    logic        vs_udr = 1'b0;
    logic [1:0]  ir_in = '0;
    logic [37:0] sr = '0;
    logic        cmd_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        cmd_valid;
    logic [1:0]  cmd_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic [2:0]  level;
    logic        ovf;

    nios2_debug_cmd_queue dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .ir_in          (ir_in),
        .sr             (sr),
        .cmd_ready      (cmd_ready),
        .ovf_clr        (ovf_clr),
        .cmd_valid      (cmd_valid),
        .cmd_ir         (cmd_ir),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .level          (level),
        .ovf            (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ir;
        logic [37:0] data;
        logic [3:0]  act;
        logic [3:0]  noact;
    } exp_t;

    exp_t sb[$];
    exp_t vec[4];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] ir, input logic [37:0] d);
        exp_t e;
        e.ir    = ir;
        e.data  = d;
        e.act   = d[37] ? (4'b0001 << ir) : 4'b0000;
        e.noact = d[37] ? 4'b0000 : (4'b0001 << ir);
        return e;
    endfunction

    // Pop side of the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cmd_valid && cmd_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: got jdo %0h expected no pop",
                             jdo);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("pop_jdo", 64'(jdo), 64'(e.data));
                    chk("pop_ir", 64'(cmd_ir), 64'(e.ir));
                    chk("pop_act", 64'(take_action), 64'(e.act));
                    chk("pop_noact", 64'(take_no_action), 64'(e.noact));
                end
            end else begin
                chk("idle_pulses", 64'({take_action, take_no_action}), 64'd0);
            end
            if (!cmd_valid)
                chk("empty_out", 64'({cmd_ir, jdo}), 64'd0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_uir(input logic [1:0] ir);
        ir_in = ir;
        cyc(1);
        vs_uir = 1'b1;
        cyc(LAT + 2);
        vs_uir = 1'b0;
        cyc(4);
    endtask

    // clr / rdy are raised only for the cycle whose closing edge pushes.
    task automatic do_udr(input logic [37:0] d, input bit clr, input bit rdy);
        sr = d;
        cyc(1);
        vs_udr = 1'b1;
        cyc(LAT);
        if (clr) ovf_clr = 1'b1;
        if (rdy) cmd_ready = 1'b1;
        cyc(1);
        if (clr) ovf_clr = 1'b0;
        if (rdy) cmd_ready = 1'b0;
        cyc(1);
        vs_udr = 1'b0;
        cyc(4);
    endtask

    task automatic wait_empty(input string nm);
        int n = 0;
        while ((cmd_valid || sb.size() != 0) && n < 40) begin
            cyc(1);
            n++;
        end
        chk({nm, "_drained"}, 64'(sb.size()), 64'd0);
        chk({nm, "_level0"}, 64'(level), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec[0] = '{IR_BREAK,     38'h20_0000_00AB, 4'b0010, 4'b0000};
        vec[1] = '{IR_TRACECTRL, 38'h00_0000_0055, 4'b0000, 4'b1000};
        vec[2] = '{IR_MONITOR,   38'h3F_FFFF_FFFF, 4'b0001, 4'b0000};
        vec[3] = '{IR_TRACE,     38'h1F_FFFF_FFFF, 4'b0000, 4'b0100};

        cyc(3);
        mon_en = 1'b1;
        chk("rst_valid", 64'(cmd_valid), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_head", 64'({cmd_ir, jdo}), 64'd0);
        reset_n = 1'b1;
        cmd_ready = 1'b1;
        cyc(6);
        chk("idle_ready_level", 64'(level), 64'd0);

        // Latency of a single command with the consumer always ready.
        do_uir(IR_BREAK);
        sb.push_back(mk(IR_BREAK, 38'h20_0000_00AB));
        sr = 38'h20_0000_00AB;
        vs_udr = 1'b1;
        cyc(LAT);
        chk("lat_not_yet", 64'(cmd_valid), 64'd0);
        cyc(1);
        chk("lat_valid", 64'(cmd_valid), 64'd1);
        chk("lat_act", 64'(take_action), 64'h2);
        chk("lat_jdo", 64'(jdo), 64'h20_0000_00AB);
        cyc(1);
        chk("lat_after", 64'(level), 64'd0);
        vs_udr = 1'b0;
        cyc(4);

        for (int i = 0; i < 4; i++) begin
            sb.push_back(vec[i]);
            do_uir(vec[i].ir);
            do_udr(vec[i].data, 1'b0, 1'b0);
            wait_empty("vec");
        end

        // Backpressure fill and overflow.
        cmd_ready = 1'b0;
        do_uir(IR_BREAK);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back(mk(IR_BREAK, 38'(i)));
            do_udr(38'(i), 1'b0, 1'b0);
        end
        chk("bp_level", 64'(level), 64'd4);
        chk("bp_ovf", 64'(ovf), 64'd1);
        chk("bp_head", 64'(jdo), 64'd1);

        do_udr(38'd6, 1'b1, 1'b0);
        chk("clr_drop_ovf", 64'(ovf), 64'd1);
        chk("clr_drop_level", 64'(level), 64'd4);

        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        chk("clr_alone", 64'(ovf), 64'd0);

        // Push against a pop while full.
        sb.push_back(mk(IR_BREAK, 38'd7));
        do_udr(38'd7, 1'b0, 1'b1);
        chk("fullpop_level", 64'(level), 64'd4);
        chk("fullpop_ovf", 64'(ovf), 64'd0);
        chk("fullpop_head", 64'(jdo), 64'd2);
        cmd_ready = 1'b1;
        wait_empty("fullpop");
        cmd_ready = 1'b0;

        // Reset while the queue holds three commands and udr is high.
        do_uir(IR_TRACE);
        for (int i = 0; i < 3; i++)
            do_udr(38'h20_0000_0010 + 38'(i), 1'b0, 1'b0);
        chk("mid_level", 64'(level), 64'd3);
        vs_udr = 1'b1;
        cyc(1);
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("mid_rst_level", 64'(level), 64'd0);
        chk("mid_rst_valid", 64'(cmd_valid), 64'd0);
        chk("mid_rst_head", 64'({cmd_ir, jdo}), 64'd0);
        chk("mid_rst_pulses", 64'({take_action, take_no_action, ovf}), 64'd0);
        cyc(3);
        reset_n = 1'b1;
        cyc(8);
        chk("held_no_push", 64'(level), 64'd0);
        vs_udr = 1'b0;
        cyc(4);
        sb.push_back(mk(IR_MONITOR, 38'h20_0000_0099));
        do_udr(38'h20_0000_0099, 1'b0, 1'b0);
        chk("rearm_level", 64'(level), 64'd1);
        cmd_ready = 1'b1;
        wait_empty("rearm");

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
